// File: rtl/rv_dmux_stream_nxw.sv
// ----------------------------------------------------------------------------
// rv_dmux_stream_nxw
//   Registered 1-to-N stream demultiplexer. One word is held in an output
//   register and presented to the channel picked by sel_in, or to every channel
//   when bcast_in is set. Each channel completes its own valid/ready handshake.
//   A word whose select is out of range is consumed and dropped. Dropping it
//   raises a one-cycle err_out pulse and bumps a saturating drop counter.
//
// Ports
//   clk_in        : clock, rising edge
//   rst_n_in      : asynchronous active-low reset
//   valid_in      : producer has a word
//   ready_out     : block accepts a word this cycle
//   data_in       : input word             [WIDTH]
//   sel_in        : destination channel    [S]
//   bcast_in      : deliver to all channels, ignore sel_in
//   valid_out     : per-channel valid      [N]
//   ready_in      : per-channel ready      [N]
//   data_out      : per-channel word       [N][WIDTH], zero when not valid
//   err_out       : pulse per dropped word
//   drop_cnt_out  : saturating drop count  [CNT_W]
// ----------------------------------------------------------------------------

// Per-channel output stage: gates the shared holding register onto one channel
// and reports whether that channel still holds a word after this cycle.
module rv_dmux_stream_nxw_lane #(
    parameter int WIDTH = 32
) (
    input  logic             pend_i,
    input  logic             ready_i,
    input  logic [WIDTH-1:0] data_i,
    output logic             valid_o,
    output logic [WIDTH-1:0] data_o,
    output logic             stall_o
);
    assign valid_o = pend_i;
    assign data_o  = pend_i ? data_i : '0;
    assign stall_o = pend_i & ~ready_i;
endmodule

module rv_dmux_stream_nxw #(
    parameter int WIDTH = 32,
    parameter int N     = 5,
    parameter int S     = $clog2(N),
    parameter int CNT_W = 8
) (
    input  logic                    clk_in,
    input  logic                    rst_n_in,
    input  logic                    valid_in,
    output logic                    ready_out,
    input  logic [WIDTH-1:0]        data_in,
    input  logic [S-1:0]            sel_in,
    input  logic                    bcast_in,
    output logic [N-1:0]            valid_out,
    input  logic [N-1:0]            ready_in,
    output logic [N-1:0][WIDTH-1:0] data_out,
    output logic                    err_out,
    output logic [CNT_W-1:0]        drop_cnt_out
);
    // One extra bit lets N itself be represented when N is a power of two.
    localparam logic [S:0] N_EXT = (S+1)'(N);

    logic [WIDTH-1:0] data_q, data_d;
    logic [N-1:0]     pend_q, pend_d;
    logic             err_q, err_d;
    logic [CNT_W-1:0] drop_q, drop_d;

    logic [N-1:0]     stall;
    logic [N-1:0]     onehot;
    logic             accept;
    logic             sel_ok;

    for (genvar i = 0; i < N; i++) begin : g_lane
        rv_dmux_stream_nxw_lane #(.WIDTH(WIDTH)) u_lane (
            .pend_i  (pend_q[i]),
            .ready_i (ready_in[i]),
            .data_i  (data_q),
            .valid_o (valid_out[i]),
            .data_o  (data_out[i]),
            .stall_o (stall[i])
        );
    end

    // Accept as soon as every pending channel handshakes this cycle, so a
    // streaming consumer sees no bubble between words.
    assign ready_out = (stall == '0);
    assign accept    = valid_in & ready_out;
    assign sel_ok    = ({1'b0, sel_in} < N_EXT);
    assign onehot    = {{(N-1){1'b0}}, 1'b1} << sel_in;

    always_comb begin
        pend_d = pend_q & ~ready_in;
        data_d = data_q;
        err_d  = 1'b0;
        drop_d = drop_q;
        if (accept) begin
            if (bcast_in) begin
                data_d = data_in;
                pend_d = '1;
            end else if (sel_ok) begin
                data_d = data_in;
                pend_d = onehot;
            end else begin
                // Bad select: swallow the word so the producer never stalls.
                pend_d = '0;
                err_d  = 1'b1;
                if (drop_q != '1) drop_d = drop_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            data_q <= '0;
            pend_q <= '0;
            err_q  <= 1'b0;
            drop_q <= '0;
        end else begin
            data_q <= data_d;
            pend_q <= pend_d;
            err_q  <= err_d;
            drop_q <= drop_d;
        end
    end

    assign err_out      = err_q;
    assign drop_cnt_out = drop_q;
endmodule

// File: tb/tb_rv_dmux_stream_nxw.sv
module tb_rv_dmux_stream_nxw;
    localparam int WIDTH = 32;
    localparam int N     = 5;
    localparam int S     = 3;
    localparam int CNT_W = 2;
    localparam int CMAX  = 3;

    logic                    clk_in = 1'b0;
    logic                    rst_n_in;
    logic                    valid_in;
    logic                    ready_out;
    logic [WIDTH-1:0]        data_in;
    logic [S-1:0]            sel_in;
    logic                    bcast_in;
    logic [N-1:0]            valid_out;
    logic [N-1:0]            ready_in;
    logic [N-1:0][WIDTH-1:0] data_out;
    logic                    err_out;
    logic [CNT_W-1:0]        drop_cnt_out;

    rv_dmux_stream_nxw #(.WIDTH(WIDTH), .N(N), .S(S), .CNT_W(CNT_W)) dut (
        .clk_in       (clk_in),
        .rst_n_in     (rst_n_in),
        .valid_in     (valid_in),
        .ready_out    (ready_out),
        .data_in      (data_in),
        .sel_in       (sel_in),
        .bcast_in     (bcast_in),
        .valid_out    (valid_out),
        .ready_in     (ready_in),
        .data_out     (data_out),
        .err_out      (err_out),
        .drop_cnt_out (drop_cnt_out)
    );

    always #5 clk_in = ~clk_in;

    int          n_chk  = 0;
    int          n_fail = 0;
    logic [31:0] expq [N][$];
    int          errq [$];
    int          exp_drop = 0;
    int          last_wait = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic clear_model();
        for (int i = 0; i < N; i++) expq[i].delete();
        errq.delete();
        exp_drop = 0;
    endtask

    // Monitor: pops a channel's expected word on each handshake, and the
    // expected drop count on each error pulse.
    always @(negedge clk_in) begin
        if (rst_n_in) begin
            for (int i = 0; i < N; i++) begin
                if (valid_out[i]) begin
                    if (expq[i].size() == 0) begin
                        chk($sformatf("unexpected_valid_ch%0d", i), 32'(valid_out[i]), 32'd0);
                    end else if (ready_in[i]) begin
                        chk($sformatf("data_ch%0d", i), data_out[i], expq[i].pop_front());
                    end
                end else if (data_out[i] != '0) begin
                    chk($sformatf("idle_zero_ch%0d", i), data_out[i], 32'd0);
                end
            end
            if (err_out) begin
                if (errq.size() == 0) chk("unexpected_err", 32'(err_out), 32'd0);
                else chk("err_drop_cnt", 32'(drop_cnt_out), 32'(errq.pop_front()));
            end
        end
    end

    task automatic push_exp(input logic [31:0] d, input logic [S-1:0] s, input logic b);
        if (b) begin
            for (int i = 0; i < N; i++) expq[i].push_back(d);
        end else if (int'(s) < N) begin
            expq[int'(s)].push_back(d);
        end else begin
            exp_drop = (exp_drop < CMAX) ? exp_drop + 1 : CMAX;
            errq.push_back(exp_drop);
        end
    endtask

    // Drive one word and hold it until accepted; returns just after the
    // accepting edge with valid_in low.
    task automatic send(input logic [31:0] d, input logic [S-1:0] s, input logic b);
        int t = 0;
        valid_in = 1'b1; data_in = d; sel_in = s; bcast_in = b;
        push_exp(d, s, b);
        @(negedge clk_in);
        while (!ready_out && t < 50) begin
            @(posedge clk_in); #1;
            @(negedge clk_in);
            t++;
        end
        if (t >= 50) chk("send_timeout", 32'(t), 32'd0);
        last_wait = t;
        @(posedge clk_in); #1;
        valid_in = 1'b0;
    endtask

    task automatic do_reset();
        @(posedge clk_in); #1;
        rst_n_in = 1'b0;
        valid_in = 1'b0;
        clear_model();
        @(negedge clk_in);
        chk("rst_valid_out", 32'(valid_out), 32'd0);
        for (int i = 0; i < N; i++) chk($sformatf("rst_data_ch%0d", i), data_out[i], 32'd0);
        chk("rst_err_out", 32'(err_out), 32'd0);
        chk("rst_drop_cnt", 32'(drop_cnt_out), 32'd0);
        chk("rst_ready_out", 32'(ready_out), 32'd1);
        @(posedge clk_in); #1;
        rst_n_in = 1'b1;
    endtask

    initial begin
        logic [N-1:0] exp_mask;
        int           raise_c [N];
        raise_c = '{1, 3, 3, 4, 6};
        rst_n_in = 1'b0; valid_in = 1'b0; data_in = '0; sel_in = '0;
        bcast_in = 1'b0; ready_in = '1;
        do_reset();

        // Reset mid-transfer: word pending on a stalled channel is discarded.
        ready_in = 5'b10111;
        send(32'h0000_0011, 3'd3, 1'b0);
        @(negedge clk_in);
        chk("pre_rst_pending", 32'(valid_out), 32'h08);
        do_reset();
        ready_in = '1;
        send(32'h0000_0077, 3'd0, 1'b0);
        repeat (2) @(posedge clk_in);
        #1;

        // Streaming, one word per cycle.
        for (int i = 0; i < N; i++) begin
            send(32'hA0 + 32'(i), S'(i), 1'b0);
            chk($sformatf("stream_no_stall_%0d", i), 32'(last_wait), 32'd0);
        end
        repeat (2) @(posedge clk_in);
        #1;

        // Backpressure on channel 2 blocks the next word for 3 cycles.
        ready_in = 5'b11011;
        send(32'h55, 3'd2, 1'b0);
        valid_in = 1'b1; data_in = 32'h66; sel_in = 3'd1; bcast_in = 1'b0;
        push_exp(32'h66, 3'd1, 1'b0);
        for (int c = 0; c < 3; c++) begin
            @(negedge clk_in);
            chk($sformatf("bp_ready_low_%0d", c), 32'(ready_out), 32'd0);
            chk($sformatf("bp_hold_ch2_%0d", c), data_out[2], 32'h55);
            @(posedge clk_in); #1;
        end
        ready_in = '1;
        @(negedge clk_in);
        chk("bp_release_ready", 32'(ready_out), 32'd1);
        @(posedge clk_in); #1;
        valid_in = 1'b0;
        @(negedge clk_in);
        chk("bp_ch1_valid", 32'(valid_out), 32'h02);
        @(posedge clk_in); #1;

        // Broadcast with staggered consumers.
        ready_in = '0;
        send(32'hDEADBEEF, 3'd0, 1'b1);
        for (int c = 1; c <= 6; c++) begin
            exp_mask = '0;
            for (int i = 0; i < N; i++) begin
                if (raise_c[i] <= c) ready_in[i] = 1'b1;
                if (raise_c[i] >= c) exp_mask[i] = 1'b1;
            end
            @(negedge clk_in);
            chk($sformatf("bc_valid_c%0d", c), 32'(valid_out), 32'(exp_mask));
            chk($sformatf("bc_ready_c%0d", c), 32'(ready_out), (c == 6) ? 32'd1 : 32'd0);
            @(posedge clk_in); #1;
        end
        @(negedge clk_in);
        chk("bc_all_done", 32'(valid_out), 32'd0);
        @(posedge clk_in); #1;

        // Back-to-back bad selects.
        send(32'h1234, 3'd6, 1'b0);
        send(32'h5678, 3'd7, 1'b0);
        @(negedge clk_in);
        chk("bad_err_2nd", 32'(err_out), 32'd1);
        @(negedge clk_in);
        chk("bad_err_clear", 32'(err_out), 32'd0);
        chk("bad_drop_cnt", 32'(drop_cnt_out), 32'd2);
        @(posedge clk_in); #1;

        // Counter saturation.
        do_reset();
        for (int k = 0; k < 5; k++) send(32'hBAD0 + 32'(k), S'(5 + (k % 3)), 1'b0);
        repeat (3) @(negedge clk_in);
        chk("sat_drop_cnt", 32'(drop_cnt_out), 32'd3);
        chk("sat_err_idle", 32'(err_out), 32'd0);

        repeat (3) @(negedge clk_in);
        for (int i = 0; i < N; i++) chk($sformatf("drain_ch%0d", i), 32'(expq[i].size()), 32'd0);
        chk("drain_err", 32'(errq.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
